// File: rtl/uart_pkg.sv
// Shared UART definitions: frame defaults, one-hot state encodings and a
// counter-width helper used by the transmitter, receiver and debug unit.
package uart_pkg;

    localparam int UART_D_BIT   = 8;   // data bits per frame
    localparam int UART_SB_TICK = 16;  // s_ticks in the stop bit (16/24/32)
    localparam int UART_OVS     = 16;  // s_ticks per start/data bit

    typedef enum logic [3:0] {
        ST_IDLE  = 4'b0001,
        ST_START = 4'b0010,
        ST_DATA  = 4'b0100,
        ST_STOP  = 4'b1000
    } uart_state_e;

    // Bits needed to count 0..n-1, never less than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: start bit, D_BIT data bits LSB first, stop bit of
// SB_TICK s_ticks. Frames start on a rising edge of tx_start while idle;
// tx and tx_done are registered.
module uart_tx
    import uart_pkg::*;
#(
    parameter int D_BIT   = UART_D_BIT,
    parameter int SB_TICK = UART_SB_TICK,
    parameter int OVS     = UART_OVS
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             s_tick,
    input  logic             tx_start,
    input  logic [D_BIT-1:0] tx_dato_in,
    output logic             tx_done,
    output logic             tx
);

    localparam int TICK_MAX = (OVS > SB_TICK) ? OVS : SB_TICK;
    localparam int TICK_W   = cnt_width(TICK_MAX);
    localparam int BIT_W    = cnt_width(D_BIT);

    localparam logic [TICK_W-1:0] OVS_LAST = TICK_W'(OVS - 1);
    localparam logic [TICK_W-1:0] SB_LAST  = TICK_W'(SB_TICK - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST = BIT_W'(D_BIT - 1);

    uart_state_e       state_q, state_d;
    logic [TICK_W-1:0] tick_q,  tick_d;
    logic [BIT_W-1:0]  bit_q,   bit_d;
    logic [D_BIT-1:0]  shreg_q, shreg_d;
    logic              tx_q,    tx_d;
    logic              done_q,  done_d;
    logic              start_prev_q;
    logic              start_cond;

    // A frame needs a fresh rising edge; the cycle carrying tx_done is
    // excluded so a back-to-back request must drop and rise again.
    assign start_cond = tx_start & ~start_prev_q & ~done_q;

    // State, counters, shift register and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            tick_q       <= '0;
            bit_q        <= '0;
            shreg_q      <= '0;
            tx_q         <= 1'b1;
            done_q       <= 1'b0;
            start_prev_q <= 1'b1;  // a level held through reset is not an edge
        end else begin
            state_q      <= state_d;
            tick_q       <= tick_d;
            bit_q        <= bit_d;
            shreg_q      <= shreg_d;
            tx_q         <= tx_d;
            done_q       <= done_d;
            start_prev_q <= tx_start;
        end
    end

    // Next-state logic; tx is derived from the next state so it is registered.
    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        done_d  = 1'b0;
        tx_d    = 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (start_cond) begin
                    state_d = ST_START;
                    tick_d  = '0;
                    bit_d   = '0;
                    shreg_d = tx_dato_in;
                end
            end
            ST_START: begin
                if (s_tick) begin
                    if (tick_q == OVS_LAST) begin
                        state_d = ST_DATA;
                        tick_d  = '0;
                        bit_d   = '0;
                    end else begin
                        tick_d = tick_q + TICK_W'(1);
                    end
                end
            end
            ST_DATA: begin
                if (s_tick) begin
                    if (tick_q == OVS_LAST) begin
                        tick_d  = '0;
                        shreg_d = shreg_q >> 1;
                        if (bit_q == BIT_LAST) begin
                            state_d = ST_STOP;
                        end else begin
                            bit_d = bit_q + BIT_W'(1);
                        end
                    end else begin
                        tick_d = tick_q + TICK_W'(1);
                    end
                end
            end
            ST_STOP: begin
                if (s_tick) begin
                    if (tick_q == SB_LAST) begin
                        state_d = ST_IDLE;
                        tick_d  = '0;
                        done_d  = 1'b1;
                    end else begin
                        tick_d = tick_q + TICK_W'(1);
                    end
                end
            end
            default: begin
                // Illegal encoding: recover to idle with clean counters.
                state_d = ST_IDLE;
                tick_d  = '0;
                bit_d   = '0;
            end
        endcase

        case (state_d)
            ST_START: tx_d = 1'b0;
            ST_DATA:  tx_d = shreg_d[0];
            default:  tx_d = 1'b1;
        endcase
    end

    assign tx      = tx_q;
    assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: two instances (1 and 2 stop bits) share all stimulus;
// a frame-level model predicts the serial line from elapsed s_ticks.
module tb_uart_tx;

    localparam int OVS = 16;
    localparam int DB  = 8;

    logic       clk;
    logic       reset;
    logic       s_tick;
    logic       tx_start;
    logic [7:0] tx_dato_in;
    logic       done0, done1;
    logic       line0, line1;

    int  n_cmp  = 0;
    int  n_fail = 0;
    logic compare_en = 1'b0;

    uart_tx #(.D_BIT(8), .SB_TICK(16), .OVS(16)) dut0 (
        .clk(clk), .reset(reset), .s_tick(s_tick), .tx_start(tx_start),
        .tx_dato_in(tx_dato_in), .tx_done(done0), .tx(line0)
    );

    uart_tx #(.D_BIT(8), .SB_TICK(32), .OVS(16)) dut1 (
        .clk(clk), .reset(reset), .s_tick(s_tick), .tx_start(tx_start),
        .tx_dato_in(tx_dato_in), .tx_done(done1), .tx(line1)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checker ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // A frame is a list of line levels: start 0, data LSB first, stop 1.
    // Only the number of s_ticks since the start condition matters.
    function automatic int frame_len(input int inst);
        return OVS * (1 + DB) + ((inst == 0) ? 16 : 32);
    endfunction

    function automatic logic exp_line(input logic busy, input int t, input logic [7:0] data);
        if (!busy)                return 1'b1;
        if (t < OVS)              return 1'b0;
        if (t < OVS * (1 + DB))   return data[(t - OVS) / OVS];
        return 1'b1;
    endfunction

    logic       m_busy [2];
    logic       m_prev [2];
    logic       m_done [2];
    int         m_t    [2];
    logic [7:0] m_data [2];

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                m_busy[i] <= 1'b0;
                m_prev[i] <= 1'b1;
                m_done[i] <= 1'b0;
                m_t[i]    <= 0;
            end else begin
                m_prev[i] <= tx_start;
                m_done[i] <= 1'b0;
                if (m_busy[i]) begin
                    if (s_tick) begin
                        m_t[i] <= m_t[i] + 1;
                        if (m_t[i] + 1 == frame_len(i)) begin
                            m_busy[i] <= 1'b0;
                            m_done[i] <= 1'b1;
                        end
                    end
                end else if (tx_start && !m_prev[i] && !m_done[i]) begin
                    m_busy[i] <= 1'b1;
                    m_t[i]    <= 0;
                    m_data[i] <= tx_dato_in;
                end
            end
        end
    end

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (compare_en) begin
            check("line0", {31'd0, line0}, {31'd0, exp_line(m_busy[0], m_t[0], m_data[0])});
            check("done0", {31'd0, done0}, {31'd0, m_done[0]});
            check("line1", {31'd0, line1}, {31'd0, exp_line(m_busy[1], m_t[1], m_data[1])});
            check("done1", {31'd0, done1}, {31'd0, m_done[1]});
        end
    end

    // ---------------- driver ----------------
    logic rec0 [0:1023];
    logic rec1 [0:1023];

    // Raise tx_start with a byte and record n cycles. Sample c is taken
    // after the c-th edge following the start edge. s_tick fires every
    // div-th edge. Optional: change the byte at sample change_at, and drop
    // tx_start at sample drop_at then raise it again one sample later.
    task automatic run_frame(input logic [7:0] data, input int div, input int n,
                             input int change_at, input int drop_at,
                             output int first0, output int first1,
                             output int pulses0, output int pulses1);
        first0 = -1; first1 = -1; pulses0 = 0; pulses1 = 0;
        @(negedge clk);
        tx_dato_in = data;
        tx_start   = 1'b1;
        s_tick     = (div == 1);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            if (c < 1024) begin
                rec0[c] = line0;
                rec1[c] = line1;
            end
            if (done0 === 1'b1) begin
                pulses0++;
                if (first0 < 0) first0 = c;
            end
            if (done1 === 1'b1) begin
                pulses1++;
                if (first1 < 0) first1 = c;
            end
            s_tick = ((c + 1) % div == 0);
            if (c == change_at)   tx_dato_in = 8'hFF;
            if (c == drop_at)     tx_start = 1'b0;
            if (c == drop_at + 1) tx_start = 1'b1;
        end
        tx_start = 1'b0;
        s_tick   = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    int f0, f1, p0, p1, bad, ones;
    int exp_a   [10] = '{0, 1, 0, 0, 0, 0, 1, 1, 0, 1};
    int exp_0x30[10] = '{0, 0, 0, 0, 0, 1, 1, 0, 0, 1};

    initial begin
        reset = 1'b1; tx_start = 1'b0; s_tick = 1'b0; tx_dato_in = 8'h00;
        @(negedge clk);
        compare_en = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_line0", {31'd0, line0}, 32'd1);
        check("reset_done0", {31'd0, done0}, 32'd0);
        check("reset_line1", {31'd0, line1}, 32'd1);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // "a" at one s_tick per clk
        run_frame(8'h61, 1, 200, -1, -1, f0, f1, p0, p1);
        check("a_done_at", f0, 160);
        check("a_pulses", p0, 1);
        for (int j = 0; j < 10; j++)
            check($sformatf("a_bit%0d", j), {31'd0, rec0[16 * j + 8]}, exp_a[j]);

        // "p" with tx_start held for 400 clk: one frame only
        run_frame(8'h70, 1, 400, -1, -1, f0, f1, p0, p1);
        check("hold_pulses0", p0, 1);
        check("hold_pulses1", p1, 1);

        // "0" with s_tick every 4th clk
        run_frame(8'h30, 4, 700, -1, -1, f0, f1, p0, p1);
        check("slow_done_at", f0, 640);
        for (int j = 0; j < 10; j++)
            check($sformatf("slow_bit%0d", j), {31'd0, rec0[64 * j + 32]}, exp_0x30[j]);

        // 0x55 on the two-stop-bit instance
        run_frame(8'h55, 1, 200, -1, -1, f0, f1, p0, p1);
        check("sb32_done_at", f1, 176);
        check("sb16_done_at", f0, 160);
        check("sb32_last_data", {31'd0, rec1[143]}, 32'd0);
        ones = 0;
        for (int c = 144; c < 176; c++) ones += int'(rec1[c]);
        check("sb32_stop_len", ones, 32);

        // byte changed to 0xFF mid-frame: captured 0x00 must be sent
        run_frame(8'h00, 1, 200, 30, -1, f0, f1, p0, p1);
        ones = 0;
        for (int c = 16; c < 144; c++) ones += int'(rec0[c]);
        check("capture_ones", ones, 0);
        check("capture_done_at", f0, 160);

        // rise coincident with tx_done must not start a frame
        run_frame(8'h5A, 1, 400, -1, 159, f0, f1, p0, p1);
        check("b2b_pulses0", p0, 1);
        check("b2b_pulses1", p1, 1);

        // reset at clk 50 of a frame
        @(negedge clk);
        tx_dato_in = 8'hC3; tx_start = 1'b1; s_tick = 1'b1;
        for (int c = 0; c < 50; c++) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; tx_start = 1'b0;
        check("midreset_line", {31'd0, line0}, 32'd1);
        bad = 0; p0 = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (line0 !== 1'b1) bad++;
            if (done0 === 1'b1) p0++;
        end
        check("midreset_idle", bad, 0);
        check("midreset_no_done", p0, 0);
        run_frame(8'hC3, 1, 200, -1, -1, f0, f1, p0, p1);
        check("after_reset_done_at", f0, 160);

        // tx_start held high through reset release
        @(negedge clk);
        reset = 1'b1; tx_start = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        bad = 0; p0 = 0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (line0 !== 1'b1) bad++;
            if (done0 === 1'b1) p0++;
        end
        check("held_reset_idle", bad, 0);
        check("held_reset_no_done", p0, 0);
        tx_start = 1'b0;
        repeat (2) @(negedge clk);

        // randomized traffic: toggling requests, noisy data, sparse resets
        for (int c = 0; c < 20000; c++) begin
            @(negedge clk);
            s_tick = ($urandom_range(0, 1) == 0);
            if ($urandom_range(0, 299) == 0) tx_start = ~tx_start;
            if ($urandom_range(0, 3) == 0)   tx_dato_in = 8'($urandom);
            reset = ($urandom_range(0, 4999) == 0);
        end
        reset = 1'b0; tx_start = 1'b0; s_tick = 1'b1;
        repeat (400) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
- REQ-001 Parameter: D_BIT, 8, number of data bits per frame.
- REQ-002 Parameter: SB_TICK, 16, s_tick count for the stop bit (16 = 1 stop bit, 24 = 1.5, 32 = 2).
- REQ-003 Parameter: OVS, 16, s_tick count per start/data bit.
- REQ-004 Port: clk  input  1  single clock; all logic on rising edge.
- REQ-005 Port: reset  input  1  synchronous, active-high reset.
- REQ-006 Port: s_tick  input  1  oversampling enable from the baud generator, one clk wide, OVS per bit period.
- REQ-007 Port: tx_start  input  1  transmit request, held as a level by the requester until tx_done.
- REQ-008 Port: tx_dato_in  input  D_BIT  byte to send, valid while tx_start is high.
- REQ-009 Port: tx_done  output  1  one-clk pulse at end of stop bit.
- REQ-010 Port: tx  output  1  serial line, idle high, registered.

Function
- REQ-011 The block SHALL use states IDLE, START, DATA, STOP, one-hot 4-bit encoded 0001/0010/0100/1000; any other encoding returns to IDLE on the next clk.
- REQ-012 The block SHALL start a frame only on a rising edge of tx_start (tx_start=1 with registered previous tx_start=0) while in IDLE; a level held high after tx_done SHALL NOT retrigger.
- REQ-013 On the start condition the block SHALL capture tx_dato_in into a shift register, clear the tick and bit counters and enter START on the same edge.
- REQ-014 tx SHALL be 1 in IDLE and STOP, 0 in START, and shift-register bit 0 in DATA, with data sent LSB first.
- REQ-015 Tick counter SHALL advance only on clk edges with s_tick=1; s_tick SHALL be ignored in IDLE.
- REQ-016 START->DATA SHALL occur on the s_tick where the tick count equals OVS-1; tick count and bit index SHALL clear.
- REQ-017 In DATA, on the s_tick where the tick count equals OVS-1, the block SHALL shift right by one and clear the tick count; on bit index D_BIT-1 it SHALL enter STOP, else increment the bit index.
- REQ-018 STOP->IDLE SHALL occur on the s_tick where the tick count equals SB_TICK-1; tx_done SHALL be 1 for exactly the following clk cycle only.
- REQ-019 Frame length SHALL be exactly OVS*(1+D_BIT)+SB_TICK s_ticks, from the start condition to the tx_done assertion.
- REQ-020 tx_start edges and tx_dato_in changes during START/DATA/STOP SHALL be ignored; the captured byte SHALL NOT change mid-frame.
- REQ-021 A start condition in the same cycle as tx_done (back-to-back) SHALL NOT start a frame; the requester SHALL deassert and reassert.
- REQ-022 Counter widths SHALL be ceil(log2(max(OVS,SB_TICK))) for ticks and ceil(log2(D_BIT)) for the bit index, with no wrap before the compare value.

Reset
- REQ-023 While reset=1 the block SHALL force state IDLE, tx=1, tx_done=0, all counters=0, shift register=0, and previous tx_start=1.
- REQ-024 Reset asserted mid-frame SHALL drive tx=1 on the next clk and SHALL NOT produce tx_done.
- REQ-025 tx_start held high through reset release SHALL NOT start a frame until it has been low for at least one clk.

Structure
- REQ-026 A shared uart package SHALL hold D_BIT, SB_TICK, OVS defaults and the four state encodings, shared with the receiver and the debug unit.
- REQ-027 The block SHALL contain no sub-module; s_tick SHALL come from the existing baud rate generator, instantiated at top level.

Verification
- REQ-028 s_tick every clk, tx_start rises with tx_dato_in=0x61 ("a") -> tx shows 0,1,0,0,0,0,1,1,0,1 for 16 clk each; tx_done pulses once at clk 160.
- REQ-029 tx_start held high for 400 clk with byte 0x70 ("p") -> exactly one frame and one tx_done pulse.
- REQ-030 s_tick every 4th clk, byte 0x30 ("0") -> each bit lasts 64 clk; tx_done after 640 clk.
- REQ-031 reset pulsed at clk 50 of a frame -> tx=1 from clk 51, no tx_done; a new tx_start rise afterward sends a full, correct frame.
- REQ-032 tx_dato_in changed to 0xFF at clk 30 of a 0x00 frame -> serial data stays all zeros.
- REQ-033 SB_TICK=32, byte 0x55 -> stop bit high for 32 ticks; tx_done at tick 176.
